// File: rtl/irq_pending_ctrl_if.sv
// irq_pending_ctrl_if
// Groups the request, presentation and status signals of irq_pending_ctrl.
//   i        [3:0] asynchronous request lines (bit 3 highest priority)
//   mask     [3:0] 1 = line may not be presented (it is still captured)
//   ack            consumer accepts the presented id
//   ovf_clr        clears every sticky overrun flag
//   valid          an id is being presented
//   o        [1:0] presented line index
//   pend     [3:0] pending vector
//   ovf      [3:0] sticky per-line overrun flags
// master = request source / consumer side, slave = the controller.
interface irq_pending_ctrl_if;
    logic [3:0] i;
    logic [3:0] mask;
    logic       ack;
    logic       ovf_clr;
    logic       valid;
    logic [1:0] o;
    logic [3:0] pend;
    logic [3:0] ovf;

    modport master (
        output i, mask, ack, ovf_clr,
        input  valid, o, pend, ovf
    );

    modport slave (
        input  i, mask, ack, ovf_clr,
        output valid, o, pend, ovf
    );
endinterface

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl
// Synchronises four asynchronous request lines, turns their rising edges into
// sticky pending bits and presents the highest-priority unmasked pending line
// to a consumer with a valid/ack handshake.
// Ports:
//   clk   single clock, rising edge
//   rst_n asynchronous active-low reset (release timing is up to the integrator)
//   bus   irq_pending_ctrl_if.slave (i, mask, ack, ovf_clr in; valid, o, pend, ovf out)
// Parameter:
//   SYNC_STAGES  synchroniser depth per request line, legal range 2..3
module irq_pending_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    irq_pending_ctrl_if.slave  bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t                        state_q;
    state_t                        state_d;
    logic [SYNC_STAGES-1:0][3:0]   sync_q;
    logic [3:0]                    sync_out;
    logic [3:0]                    hist_q;
    logic [3:0]                    rise;
    logic [3:0]                    pend_q;
    logic [3:0]                    pend_d;
    logic [3:0]                    ovf_q;
    logic [3:0]                    ovf_d;
    logic [3:0]                    avail;
    logic [3:0]                    ack_clr;
    logic [3:0]                    overrun;
    logic [1:0]                    o_q;
    logic [1:0]                    o_d;
    logic [1:0]                    sel;
    logic                          take;

    assign sync_out = sync_q[SYNC_STAGES-1];
    // The history register starts at 0, so a line already high when reset
    // is released still produces one edge.
    assign rise     = sync_out & ~hist_q;
    assign avail    = pend_q & ~bus.mask;

    // Synchroniser chain plus one-flop history per request line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i};
            hist_q <= sync_out;
        end
    end

    // Highest set bit of the unmasked pending vector.
    always_comb begin
        sel = 2'd0;
        if (avail[3]) begin
            sel = 2'd3;
        end else if (avail[2]) begin
            sel = 2'd2;
        end else if (avail[1]) begin
            sel = 2'd1;
        end
    end

    // Pending, overrun and latched-id next values. A pending bit cleared by
    // ack in the same cycle as a new edge simply stays set, with no overrun.
    // A new overrun beats ovf_clr.
    always_comb begin
        take    = (state_q == IDLE) && (avail != 4'b0000);
        ack_clr = 4'b0000;
        if ((state_q == PRESENT) && bus.ack) begin
            ack_clr = 4'b0001 << o_q;
        end
        overrun = rise & pend_q & ~ack_clr;
        pend_d  = (pend_q & ~ack_clr) | rise;
        ovf_d   = (bus.ovf_clr ? 4'b0000 : ovf_q) | overrun;
        o_d     = take ? sel : o_q;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 4'b0000;
            ovf_q  <= 4'b0000;
            o_q    <= 2'b00;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            o_q    <= o_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Returning to IDLE on ack guarantees a one-cycle valid=0 bubble, because
    // a new presentation can only start from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (avail != 4'b0000) state_d = PRESENT;
            PRESENT: if (bus.ack)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are direct decodes of registers.
    always_comb begin
        bus.valid = (state_q == PRESENT);
        bus.o     = o_q;
        bus.pend  = pend_q;
        bus.ovf   = ovf_q;
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// tb_irq_pending_ctrl
// Directed bench for irq_pending_ctrl (SYNC_STAGES = 2). Expected presentation
// ids are pushed to a scoreboard queue as stimulus is driven and popped when
// the controller raises valid.
module tb_irq_pending_ctrl;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   passed = 0;
    logic [1:0] expQ[$];

    irq_pending_ctrl_if bus ();

    irq_pending_ctrl #(
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance n clock edges, landing 1 unit after the last rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive all synchronous and request inputs at once.
    task automatic applyStimulus(input logic [3:0] iv, input logic [3:0] maskv,
                                 input logic ackv, input logic clrv);
        bus.i       = iv;
        bus.mask    = maskv;
        bus.ack     = ackv;
        bus.ovf_clr = clrv;
    endtask

    task automatic setI(input logic [3:0] iv);
        applyStimulus(iv, bus.mask, bus.ack, bus.ovf_clr);
    endtask

    // One comparison; passed is only stepped when the observation matches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Wait (bounded) for valid, compare o against the scoreboard head and
    // optionally ack, checking the valid=0 bubble that must follow.
    task automatic servicePresent(input string tag, input bit doAck);
        logic [1:0] expId;
        int waited;
        waited = 0;
        while (bus.valid !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput({tag, "_valid"}, {31'd0, bus.valid}, 32'd1);
        if (expQ.size() == 0) begin
            checks++;
            $error("[TB] FAIL %s_sb: observed o=%0h required no presentation", tag, bus.o);
        end else begin
            expId = expQ.pop_front();
            checkOutput({tag, "_o"}, {30'd0, bus.o}, {30'd0, expId});
        end
        if (doAck) begin
            applyStimulus(bus.i, bus.mask, 1'b1, 1'b0);
            tick();
            applyStimulus(bus.i, bus.mask, 1'b0, 1'b0);
            checkOutput({tag, "_bubble"}, {31'd0, bus.valid}, 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Reset state, before any clock edge.
        #2;
        checkOutput("rst_valid", {31'd0, bus.valid}, 32'd0);
        checkOutput("rst_pend",  {28'd0, bus.pend},  32'd0);
        checkOutput("rst_ovf",   {28'd0, bus.ovf},   32'd0);
        checkOutput("rst_o",     {30'd0, bus.o},     32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Single 3-cycle pulse on line 1: pend after edge k+2, valid after k+3.
        setI(4'b0010);
        tick(2);
        checkOutput("p1_pend_early", {28'd0, bus.pend}, 32'd0);
        tick();
        setI(4'b0000);
        checkOutput("p1_pend",  {28'd0, bus.pend},  32'h2);
        checkOutput("p1_valid0", {31'd0, bus.valid}, 32'd0);
        expQ.push_back(2'd1);
        tick();
        checkOutput("p1_valid1", {31'd0, bus.valid}, 32'd1);
        servicePresent("p1", 1'b1);
        checkOutput("p1_pend_clr", {28'd0, bus.pend}, 32'd0);

        // Ack while idle does nothing.
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("idle_ack_valid", {31'd0, bus.valid}, 32'd0);
        checkOutput("idle_ack_pend",  {28'd0, bus.pend},  32'd0);
        tick(3);

        // Simultaneous edges on lines 2 and 0: line 2 first, then line 0.
        setI(4'b0101);
        expQ.push_back(2'd2);
        expQ.push_back(2'd0);
        tick(3);
        setI(4'b0000);
        checkOutput("p2_pend", {28'd0, bus.pend}, 32'h5);
        servicePresent("p2a", 1'b1);
        servicePresent("p2b", 1'b1);
        tick(3);
        checkOutput("p2_idle_valid", {31'd0, bus.valid}, 32'd0);
        checkOutput("p2_idle_pend",  {28'd0, bus.pend},  32'd0);

        // Higher-priority arrival during a presentation must not disturb o.
        setI(4'b0001);
        expQ.push_back(2'd0);
        tick(3);
        setI(4'b0000);
        servicePresent("p3a", 1'b0);
        setI(4'b1000);
        expQ.push_back(2'd3);
        tick(4);
        setI(4'b0000);
        checkOutput("p3_hold_valid", {31'd0, bus.valid}, 32'd1);
        checkOutput("p3_hold_o",     {30'd0, bus.o},     32'd0);
        checkOutput("p3_hold_pend",  {28'd0, bus.pend},  32'h9);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("p3_bubble", {31'd0, bus.valid}, 32'd0);
        servicePresent("p3b", 1'b1);
        tick(3);

        // Masked line is captured but not presented until unmasked.
        applyStimulus(4'b1000, 4'b1000, 1'b0, 1'b0);
        tick(3);
        setI(4'b0000);
        tick(4);
        checkOutput("p4_pend",  {28'd0, bus.pend},  32'h8);
        checkOutput("p4_valid", {31'd0, bus.valid}, 32'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        expQ.push_back(2'd3);
        servicePresent("p4", 1'b1);
        checkOutput("p4_pend_clr", {28'd0, bus.pend}, 32'd0);
        tick(3);

        // Overrun, clear, clear-vs-set collision, ack-vs-edge collision.
        setI(4'b0010);
        expQ.push_back(2'd1);
        tick(3);
        setI(4'b0000);
        tick(4);
        servicePresent("p5a", 1'b0);
        setI(4'b0010);
        tick(3);
        setI(4'b0000);
        tick(4);
        checkOutput("p5_ovf",  {28'd0, bus.ovf},  32'h2);
        checkOutput("p5_pend", {28'd0, bus.pend}, 32'h2);
        checkOutput("p5_o",    {30'd0, bus.o},    32'd1);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("p5_ovf_clr", {28'd0, bus.ovf}, 32'd0);
        setI(4'b0010);
        tick(2);
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b1);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("p5_set_wins", {28'd0, bus.ovf}, 32'h2);
        tick(4);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        setI(4'b0010);
        tick(2);
        applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("p5_ackedge_pend",  {28'd0, bus.pend},  32'h2);
        checkOutput("p5_ackedge_ovf",   {28'd0, bus.ovf},   32'd0);
        checkOutput("p5_ackedge_valid", {31'd0, bus.valid}, 32'd0);
        expQ.push_back(2'd1);
        servicePresent("p5b", 1'b1);
        checkOutput("p5_pend_clr", {28'd0, bus.pend}, 32'd0);
        tick(3);

        // Reset mid-presentation, then a line held high through release.
        setI(4'b0001);
        expQ.push_back(2'd0);
        tick(3);
        setI(4'b0000);
        tick(4);
        servicePresent("p6a", 1'b0);
        setI(4'b0001);
        tick(3);
        setI(4'b0000);
        tick(4);
        checkOutput("p6_ovf_pre", {28'd0, bus.ovf}, 32'h1);
        setI(4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("p6_rst_valid", {31'd0, bus.valid}, 32'd0);
        checkOutput("p6_rst_pend",  {28'd0, bus.pend},  32'd0);
        checkOutput("p6_rst_ovf",   {28'd0, bus.ovf},   32'd0);
        tick(2);
        rst_n = 1'b1;
        expQ.push_back(2'd2);
        servicePresent("p6b", 1'b1);
        tick(8);
        checkOutput("p6_once_valid", {31'd0, bus.valid}, 32'd0);
        checkOutput("p6_once_pend",  {28'd0, bus.pend},  32'd0);
        setI(4'b0000);

        checkOutput("sb_empty", expQ.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/irq_pending_ctrl.md
IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchroniser flops per request line (legal values 2..3).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: i  input  4  asynchronous request lines; bit 3 highest priority, bit 0 lowest.
REQ-005 Port: mask  input  4  synchronous; 1 = line blocked from presentation; capture still occurs.
REQ-006 Port: ack  input  1  consumer accepts the presented id; meaningful only while valid=1.
REQ-007 Port: valid  output  1  registered; an id is being presented.
REQ-008 Port: o  output  2  registered; presented line index (3..0), encoded as the downstream priority encoder expects.
REQ-009 Port: pend  output  4  registered pending vector, for the downstream encoder and for debug.
REQ-010 Port: ovf  output  4  registered sticky per-line overrun flags.
REQ-011 Port: ovf_clr  input  1  synchronous; clears all ovf bits.

Function
REQ-012 Each bit of i SHALL pass through a SYNC_STAGES-deep flop chain followed by a one-flop history register; edge = sync_out & ~history.
REQ-013 A rising edge on line n SHALL set pend[n] at the same clock edge at which the history register updates. With SYNC_STAGES=2, if i[n] is first sampled high at edge k, pend[n] is set at edge k+2.
REQ-014 Levels SHALL NOT retrigger: a line held high sets pend once; it must go low for at least SYNC_STAGES+1 cycles and rise again to produce another edge.
REQ-015 An edge on a line whose pend bit is already 1, and not being cleared that cycle, SHALL set ovf[n]; pend[n] stays 1, and there is no event count.
REQ-016 The FSM SHALL have two states: IDLE (valid=0) and PRESENT (valid=1).
REQ-017 IDLE -> PRESENT: at an edge where (pend & ~mask) != 0, latch o = index of the highest set bit of (pend & ~mask). valid rises after that edge.
REQ-018 PRESENT: o SHALL hold stable regardless of new edges, higher-priority arrivals or mask changes until ack.
REQ-019 PRESENT with ack=1: at that edge clear pend[o] and return to IDLE. There SHALL be a minimum one-cycle valid=0 bubble between consecutive presentations.
REQ-020 ack while in IDLE SHALL be ignored, with no state change.
REQ-021 Ack-clear and a new edge on the same line in the same cycle: pend[n] remains 1 and ovf[n] is unchanged (no overrun).
REQ-022 Edges on multiple lines in the same cycle SHALL all be captured in that cycle.
REQ-023 ovf_clr and a new overrun in the same cycle: the set wins and ovf[n] = 1.
REQ-024 When all unmasked pend bits are 0, the FSM stays in IDLE; o holds its last value and is don't-care while valid=0.

Reset
REQ-025 When rst_n=0, all flops SHALL clear immediately: sync chains, history, pend=0, ovf=0, valid=0, o=2'b00, FSM=IDLE.
REQ-026 Reset asserted mid-presentation SHALL discard the pending event without requiring ack.
REQ-027 A line that is high at reset release SHALL be treated as a rising edge, because history resets to 0.
REQ-028 Reset deassertion timing SHALL be the integrator's responsibility; no internal reset synchroniser is provided.

Verification
REQ-029 Pulse i=4'b0010 for 3 cycles, mask=0 -> pend=4'b0010 at edge k+2; valid=1, o=2'b01 after edge k+3; ack one cycle -> pend=0, valid=0.
REQ-030 i=4'b0101 rising simultaneously, ack each presentation immediately -> o=2'b10 first, then one valid=0 bubble, then o=2'b00, then valid stays 0.
REQ-031 Present o=2'b00, then raise i[3] before ack -> o stays 2'b00 until ack; after the bubble, o=2'b11 is presented.
REQ-032 mask=4'b1000 with i[3] pulsed -> pend=4'b1000 and valid stays 0; clear mask -> valid=1 with o=2'b11.
REQ-033 Pulse i[1] twice with no ack -> ovf=4'b0010 and pend[1]=1; ovf_clr -> ovf=0; pulse i[1] again on the same cycle as ack of o=2'b01 -> pend[1]=1 and ovf stays 0.
REQ-034 Drop rst_n while valid=1 -> valid=0, pend=0, ovf=0 without a clock edge; i[2] held high through reset release -> one presentation of o=2'b10 only.
